// File: rtl/lcd1602_pkg.sv
// Shared constants and state encoding for the HD44780 16x2 LCD controller.
package lcd1602_pkg;

    localparam logic [7:0] CMD_FUNC_SET   = 8'h38;
    localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
    localparam logic [7:0] CMD_DISP_BLINK = 8'h0F;
    localparam logic [7:0] CMD_CLEAR      = 8'h01;
    localparam logic [7:0] CMD_ENTRY      = 8'h06;
    localparam logic [7:0] CMD_LINE1      = 8'h80;
    localparam logic [7:0] CMD_LINE2      = 8'hC0;
    localparam logic [7:0] CMD_DYN_POS    = 8'hCF;

    localparam int MSG_LEN = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_CMD_L1,
        ST_TXT_L1,
        ST_CMD_L2,
        ST_TXT_L2,
        ST_DYN,
        ST_WAIT
    } state_e;

endpackage

// File: rtl/lcd1602_if.sv
// Host-side control inputs and LCD pin outputs of the controller.
interface lcd1602_if;
    logic       ready_i;
    logic       message_change;
    logic [1:0] sel_msg;
    logic [7:0] data_in;
    logic       rs;
    logic       rw;
    logic       enable;
    logic [7:0] data;

    modport master (
        output ready_i, message_change, sel_msg, data_in,
        input  rs, rw, enable, data
    );

    modport slave (
        input  ready_i, message_change, sel_msg, data_in,
        output rs, rw, enable, data
    );
endinterface

// File: rtl/lcd1602_msg_rom.sv
// Combinational 32-char message ROM; line 1 is chars 0..15, line 2 is 16..31.
module lcd1602_msg_rom
    import lcd1602_pkg::*;
#(
    parameter int NUM_MSG = 4
) (
    input  logic [1:0] sel,
    input  logic [4:0] idx,
    output logic [7:0] char
);

    localparam logic [8*MSG_LEN-1:0] MSG0 = {"LCD1602 READY   ", "KEYPAD:         "};
    localparam logic [8*MSG_LEN-1:0] MSG1 = {"SELECT MODE     ", "PRESS A-D       "};
    localparam logic [8*MSG_LEN-1:0] MSG2 = {"ENTER CODE      ", "CODE:           "};
    localparam logic [8*MSG_LEN-1:0] MSG3 = {"SYSTEM LOCKED   ", "WAIT...         "};

    logic [8*MSG_LEN-1:0] msg;
    logic [4:0]           ridx;

    always_comb begin
        msg = MSG0;
        // Indices beyond the populated message count fall back to message 0.
        if (32'(sel) < NUM_MSG) begin
            case (sel)
                2'd1:    msg = MSG1;
                2'd2:    msg = MSG2;
                2'd3:    msg = MSG3;
                default: msg = MSG0;
            endcase
        end
        ridx = 5'd31 - idx;
        char = msg[{ridx, 3'b000} +: 8];
    end

endmodule

// File: rtl/lcd1602_controller.sv
// HD44780 16x2 write-only controller: init, 32-char ROM message, one live char at line 2 col 15.
// Define LCD_CURSOR_BLINK_EN to turn the cursor on with blink in the init sequence.
module lcd1602_controller
    import lcd1602_pkg::*;
#(
    parameter int DELAY_CYCLES = 50000,
    parameter int NUM_MSG      = 4
) (
    input logic       clk,
    input logic       reset,
    lcd1602_if.slave  bus
);

`ifdef LCD_CURSOR_BLINK_EN
    localparam logic [7:0] CMD_DISP = CMD_DISP_BLINK;
`else
    localparam logic [7:0] CMD_DISP = CMD_DISP_ON;
`endif

    localparam int              CW   = $clog2(DELAY_CYCLES);
    localparam logic [CW-1:0]   LAST = CW'(DELAY_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic          tick;
    state_e        state_q, state_d, nxt_st;
    logic [4:0]    idx_q, idx_d, nxt_idx;
    logic          ph_q, ph_d;
    logic          rs_q, rs_d, en_q, en_d;
    logic [7:0]    data_q, data_d;
    logic [1:0]    msel_q, msel_d;
    logic [7:0]    last_q, last_d;
    logic          pend_q, pend_d;
    logic          emit, consume, b_rs;
    logic [7:0]    b_val, init_byte, rom_char;

    assign tick       = (cnt_q == LAST);
    assign bus.rs     = rs_q;
    assign bus.rw     = 1'b0;
    assign bus.enable = en_q;
    assign bus.data   = data_q;

    lcd1602_msg_rom #(.NUM_MSG(NUM_MSG)) u_rom (
        .sel  (msel_q),
        .idx  (idx_q),
        .char (rom_char)
    );

    always_comb begin
        case (idx_q[1:0])
            2'd0:    init_byte = CMD_FUNC_SET;
            2'd1:    init_byte = CMD_DISP;
            2'd2:    init_byte = CMD_CLEAR;
            default: init_byte = CMD_ENTRY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            idx_q   <= '0;
            ph_q    <= 1'b0;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            data_q  <= 8'h00;
            msel_q  <= 2'd0;
            last_q  <= 8'h20;
            pend_q  <= 1'b0;
        end else begin
            cnt_q   <= tick ? '0 : cnt_q + 1'b1;
            state_q <= state_d;
            idx_q   <= idx_d;
            ph_q    <= ph_d;
            rs_q    <= rs_d;
            en_q    <= en_d;
            data_q  <= data_d;
            msel_q  <= msel_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ph_d    = ph_q;
        rs_d    = rs_q;
        en_d    = en_q;
        data_d  = data_q;
        msel_d  = msel_q;
        last_d  = last_q;
        consume = 1'b0;
        emit    = 1'b1;
        b_rs    = 1'b0;
        b_val   = 8'h00;
        nxt_st  = state_q;
        nxt_idx = idx_q + 5'd1;

        // Byte source for the current state and where to go after its falling edge.
        case (state_q)
            ST_INIT: begin
                b_val = init_byte;
                if (idx_q == 5'd3) begin
                    nxt_st  = ST_CMD_L1;
                    nxt_idx = 5'd0;
                end
            end
            ST_CMD_L1: begin
                b_val   = CMD_LINE1;
                nxt_st  = ST_TXT_L1;
                nxt_idx = 5'd0;
            end
            ST_TXT_L1: begin
                b_rs  = 1'b1;
                b_val = rom_char;
                if (idx_q == 5'd15) begin
                    nxt_st  = ST_CMD_L2;
                    nxt_idx = 5'd0;
                end
            end
            ST_CMD_L2: begin
                b_val   = CMD_LINE2;
                nxt_st  = ST_TXT_L2;
                nxt_idx = 5'd16;
            end
            ST_TXT_L2: begin
                b_rs  = 1'b1;
                b_val = rom_char;
                if (idx_q == 5'd30) begin
                    nxt_st  = ST_DYN;
                    nxt_idx = 5'd0;
                end
            end
            ST_DYN: begin
                if (idx_q == 5'd0) begin
                    b_val = CMD_DYN_POS;
                end else begin
                    b_rs    = 1'b1;
                    b_val   = bus.data_in;
                    nxt_st  = ST_WAIT;
                    nxt_idx = 5'd0;
                end
            end
            ST_WAIT: begin
                // The clear command is the only byte WAIT emits; ph_q keeps it alive for phase 2.
                emit    = ph_q | pend_q;
                b_val   = CMD_CLEAR;
                nxt_st  = ST_CMD_L1;
                nxt_idx = 5'd0;
            end
            default: emit = 1'b0;
        endcase

        if (tick) begin
            if (emit && !ph_q) begin
                rs_d   = b_rs;
                data_d = b_val;
                en_d   = 1'b1;
                ph_d   = 1'b1;
                if (state_q == ST_DYN && idx_q != 5'd0) last_d = bus.data_in;
                if (state_q == ST_WAIT) consume = 1'b1;
            end else if (emit) begin
                en_d    = 1'b0;
                ph_d    = 1'b0;
                state_d = nxt_st;
                idx_d   = nxt_idx;
                if (nxt_st == ST_CMD_L1) msel_d = bus.sel_msg;
            end else if (state_q == ST_IDLE) begin
                if (bus.ready_i) begin
                    state_d = ST_INIT;
                    idx_d   = 5'd0;
                end
            end else if (state_q == ST_WAIT && bus.data_in != last_q) begin
                state_d = ST_DYN;
                idx_d   = 5'd0;
            end
        end

        pend_d = bus.message_change | (pend_q & ~consume);
    end

endmodule

// File: tb/tb_lcd1602_controller.sv
// Directed bench: expected LCD bytes are queued as stimulus is applied and popped on each E falling edge.
module tb_lcd1602_controller;

    localparam int DLY = 4;

`ifdef LCD_CURSOR_BLINK_EN
    localparam logic [7:0] DISP2 = 8'h0F;
`else
    localparam logic [7:0] DISP2 = 8'h0C;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lcd1602_if bus ();

    lcd1602_controller #(.DELAY_CYCLES(DLY), .NUM_MSG(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         n_chk  = 0;
    int         n_pass = 0;
    int         n_fail = 0;
    int         n_wr   = 0;
    int         hi_cnt = 0;
    logic       en_prev = 1'b0;
    logic [8:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] msg_char(input int m, input int i);
        logic [255:0] s;
        case (m)
            1:       s = {"SELECT MODE     ", "PRESS A-D       "};
            2:       s = {"ENTER CODE      ", "CODE:           "};
            3:       s = {"SYSTEM LOCKED   ", "WAIT...         "};
            default: s = {"LCD1602 READY   ", "KEYPAD:         "};
        endcase
        return s[8*(31-i) +: 8];
    endfunction

    task automatic push(input logic r, input logic [7:0] b);
        sb.push_back({r, b});
    endtask

    task automatic push_init();
        push(1'b0, 8'h38); push(1'b0, DISP2); push(1'b0, 8'h01); push(1'b0, 8'h06);
    endtask

    task automatic push_body(input int m, input logic [7:0] dyn);
        push(1'b0, 8'h80);
        for (int i = 0; i < 16; i++) push(1'b1, msg_char(m, i));
        push(1'b0, 8'hC0);
        for (int i = 16; i < 31; i++) push(1'b1, msg_char(m, i));
        push(1'b0, 8'hCF);
        push(1'b1, dyn);
    endtask

    task automatic drain(input string tag, input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk(tag, sb.size(), 0);
    endtask

    task automatic wait_writes(input string tag, input int n, input int budget);
        int k = 0;
        while (n_wr < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk(tag, 32'(n_wr >= n), 1);
    endtask

    task automatic idle_check(input string tag, input int cycles);
        int w;
        w = n_wr;
        repeat (cycles) @(posedge clk);
        chk(tag, n_wr, w);
    endtask

    task automatic pulse_mc();
        @(posedge clk); #2;
        bus.message_change = 1'b1;
        @(posedge clk); #2;
        bus.message_change = 1'b0;
    endtask

    // Monitor: every E falling edge outside reset delivers one byte.
    always @(negedge clk) begin
        logic [8:0] exp;
        if (!reset) begin
            en_prev = 1'b0;
            hi_cnt  = 0;
        end else begin
            if (bus.enable) begin
                hi_cnt++;
            end else if (en_prev) begin
                chk("en_width", hi_cnt, DLY);
                chk("expected_write", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp = sb.pop_front();
                    chk("byte", {23'd0, bus.rs, bus.data}, {23'd0, exp});
                end
                n_wr++;
                hi_cnt = 0;
            end
            en_prev = bus.enable;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int k;
        bus.ready_i        = 1'b0;
        bus.message_change = 1'b0;
        bus.sel_msg        = 2'b01;
        bus.data_in        = 8'h20;
        #1 reset = 1'b0;
        #1;
        chk("rst_enable", bus.enable, 1'b0);
        chk("rst_data",   bus.data,   8'h00);
        chk("rst_rs",     bus.rs,     1'b0);
        chk("rst_rw",     bus.rw,     1'b0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;

        // ready_i low: bus must stay quiet
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_bus", {bus.rs, bus.enable, bus.data}, 10'h000);
        end

        // Power-up sequence and message 1, dynamic char 0x20
        push_init();
        push_body(1, 8'h20);
        @(posedge clk); #2;
        bus.ready_i = 1'b1;
        drain("drain_init", 1000);
        idle_check("quiet_after_init", 60);

        // Dynamic char change: exactly CF then 35
        push(1'b0, 8'hCF);
        push(1'b1, 8'h35);
        @(posedge clk); #2;
        bus.data_in = 8'h35;
        drain("drain_dyn", 200);
        idle_check("quiet_after_dyn", 60);

        // Rewrite with msg 1; mid-TXT_L1 select msg 2 and request twice (collapses to one rewrite)
        push(1'b0, 8'h01); push_body(1, 8'h35);
        push(1'b0, 8'h01); push_body(2, 8'h35);
        base = n_wr;
        pulse_mc();
        wait_writes("reach_txt_l1", base + 5, 400);
        @(posedge clk); #2;
        bus.sel_msg = 2'b10;
        pulse_mc();
        wait_writes("reach_txt_l1_b", base + 9, 400);
        pulse_mc();
        drain("drain_rewrite", 2000);
        idle_check("quiet_after_rewrite", 80);

        // Reset while E is high mid-text, then full restart from 0x38
        push(1'b0, 8'h01); push_body(2, 8'h35);
        base = n_wr;
        pulse_mc();
        wait_writes("reach_txt_rst", base + 6, 400);
        k = 0;
        while (!bus.enable && k < 40) begin
            @(posedge clk); #2;
            k++;
        end
        chk("en_high_pre_rst", bus.enable, 1'b1);
        reset = 1'b0;
        #1;
        chk("rst_mid_enable", bus.enable, 1'b0);
        chk("rst_mid_data",   bus.data,   8'h00);
        chk("rst_mid_rs",     bus.rs,     1'b0);
        sb.delete();
        repeat (3) @(posedge clk);
        push_init();
        push_body(2, 8'h35);
        #2 reset = 1'b1;
        drain("drain_restart", 1000);
        idle_check("quiet_after_restart", 60);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
